pingpong_bank_arbiter: RTL

//  Owns the two group-buffer RAM banks shared by the Orbita frame filler (writer) and the
//  M8 frame former (reader). Hands banks between the two sides, gates RAM write/read enables,
//  and steers read data. Counts overruns (writer blocked) and underruns (reader repeats a bank).

---
 rtl/pingpong_bank_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/pingpong_bank_arbiter.sv
// Two-bank ping-pong arbiter between a group writer and a frame reader.
// Tracks per-bank ownership, gates RAM enables, steers read data, counts overruns/underruns.
module pingpong_bank_arbiter #(
  parameter int DATA_W     = 12,
  parameter int ADDR_W     = 10,
  parameter int CNT_W      = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wrEn,
  input  logic              wrDone,
  input  logic              rdEn,
  input  logic              rdSwap,
  input  logic [DATA_W-1:0] m0_DO,
  input  logic [DATA_W-1:0] m1_DO,
  output logic              m0_WE,
  output logic              m1_WE,
  output logic              m0_RE,
  output logic              m1_RE,
  output logic [DATA_W-1:0] rdData,
  output logic              rdBank,
  output logic              wrReady,
  output logic              underrun,
  output logic [CNT_W-1:0]  overrunCnt,
  output logic [CNT_W-1:0]  underrunCnt
);

  if ((RD_LATENCY < 1) || (RD_LATENCY > 3) || (ADDR_W < 1)) begin : g_bad_param
    $error("pingpong_bank_arbiter: RD_LATENCY must be 1..3 and ADDR_W >= 1");
  end

  typedef enum logic [1:0] {FREE = 2'd0, FILL = 2'd1, READY = 2'd2, READ = 2'd3} bank_st_e;

  bank_st_e st0, st1, st0_nxt, st1_nxt;
  logic     rd_bank, rd_bank_nxt;
  logic     swap_ok, underrun_nxt, wr_ready;

  logic [RD_LATENCY:1] bank_pipe, vld_pipe;

  assign wr_ready = (st0 == FILL) || (st1 == FILL);

  // wrDone is folded in before the swap decision so a same-cycle swap sees the fresh READY bank.
  always_comb begin
    st0_nxt     = st0;
    st1_nxt     = st1;
    rd_bank_nxt = rd_bank;
    swap_ok     = 1'b0;
    if (wrDone && wr_ready) begin
      if (st0 == FILL) st0_nxt = READY;
      if (st1 == FILL) st1_nxt = READY;
    end
    // The released bank passes through FREE straight to FILL: no bank can be in FILL here.
    if (rdSwap) begin
      if (!rd_bank && (st1_nxt == READY)) begin
        st1_nxt     = READ;
        st0_nxt     = FILL;
        rd_bank_nxt = 1'b1;
        swap_ok     = 1'b1;
      end else if (rd_bank && (st0_nxt == READY)) begin
        st0_nxt     = READ;
        st1_nxt     = FILL;
        rd_bank_nxt = 1'b0;
        swap_ok     = 1'b1;
      end
    end
    underrun_nxt = rdSwap && !swap_ok;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      st0         <= READ;
      st1         <= FILL;
      rd_bank     <= 1'b0;
      underrun    <= 1'b0;
      overrunCnt  <= '0;
      underrunCnt <= '0;
    end else begin
      st0      <= st0_nxt;
      st1      <= st1_nxt;
      rd_bank  <= rd_bank_nxt;
      underrun <= underrun_nxt;
      if (wrEn && !wr_ready && (overrunCnt != '1))
        overrunCnt <= overrunCnt + 1'b1;
      if (underrun_nxt && (underrunCnt != '1))
        underrunCnt <= underrunCnt + 1'b1;
    end
  end

  // Bank select travels with each read so words in flight at a swap come from the old bank.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bank_pipe <= '0;
      vld_pipe  <= '0;
    end else begin
      bank_pipe[1] <= rd_bank;
      vld_pipe[1]  <= rdEn;
      for (int i = 2; i <= RD_LATENCY; i++) begin
        bank_pipe[i] <= bank_pipe[i-1];
        vld_pipe[i]  <= vld_pipe[i-1];
      end
    end
  end

  assign rdData = vld_pipe[RD_LATENCY] ? (bank_pipe[RD_LATENCY] ? m1_DO : m0_DO) : '0;

  assign m0_WE   = wrEn && wr_ready && (st0 == FILL);
  assign m1_WE   = wrEn && wr_ready && (st1 == FILL);
  assign m0_RE   = rdEn && !rd_bank;
  assign m1_RE   = rdEn && rd_bank;
  assign rdBank  = rd_bank;
  assign wrReady = wr_ready;

endmodule
